// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pkg
//  Brief    : Shared psum widths, row type, clear-FSM states and the signed
//             saturating add used by the partial-sum buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int BW_PSUM    = 20;
    localparam int COL        = 8;
    localparam int PSUM_DEPTH = 16;
    localparam int ROW_W      = BW_PSUM * COL;
    localparam int SUM_W      = BW_PSUM + $clog2(COL) + 1;

    typedef logic signed [BW_PSUM-1:0] psum_t;
    typedef psum_t [COL-1:0]           psum_row_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam psum_t C_PSUM_MAX = {1'b0, {(BW_PSUM-1){1'b1}}};
    localparam psum_t C_PSUM_MIN = {1'b1, {(BW_PSUM-1){1'b0}}};

    // Signed add that clamps to the representable range instead of wrapping.
    function automatic psum_t sat_add(input psum_t a, input psum_t b);
        logic [BW_PSUM:0] w_sum;
        w_sum = {a[BW_PSUM-1], a} + {b[BW_PSUM-1], b};
        if (w_sum[BW_PSUM] != w_sum[BW_PSUM-1]) begin
            sat_add = w_sum[BW_PSUM] ? C_PSUM_MIN : C_PSUM_MAX;
        end else begin
            sat_add = w_sum[BW_PSUM-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_abs_sum.sv
`default_nettype none
// ============================================================================
//  Module   : psum_abs_sum
//  Brief    : Sum of absolute lane values of one psum row, registered
//             (one cycle from i_valid to o_valid).
//  Revision : 1.0 - initial release
// ============================================================================
module psum_abs_sum
    import core_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ROW_W-1:0] i_row,
    input  logic             i_valid,
    output logic [SUM_W-1:0] o_sum,
    output logic             o_valid
);

    psum_row_t        w_row;
    logic [SUM_W-1:0] w_total;

    assign w_row = i_row;

    // |x| as an unsigned lane; the most negative value maps to 2^(BW_PSUM-1) exactly.
    function automatic logic [BW_PSUM-1:0] abs_lane(input psum_t x);
        abs_lane = x[BW_PSUM-1] ? BW_PSUM'(~x + psum_t'(1)) : BW_PSUM'(x);
    endfunction

    // Adder tree over the lane magnitudes; SUM_W leaves headroom for COL maxima.
    always_comb begin
        w_total = '0;
        for (int i = 0; i < COL; i++) begin
            w_total = w_total + SUM_W'(abs_lane(w_row[i]));
        end
    end

    // Output register for the sum and its single-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_sum   <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_sum <= w_total;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_accum_mem.sv
`default_nettype none
// ============================================================================
//  Module   : psum_accum_mem
//  Brief    : Row-addressed partial-sum buffer with overwrite / saturating
//             accumulate writes, forwarding from the write stage, full-array
//             clear and row readout with sum of absolute lane values.
//  Revision : 1.0 - initial release
// ============================================================================
module psum_accum_mem
    import core_pkg::*;
#(
    parameter  int DEPTH  = PSUM_DEPTH,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ROW_W-1:0]  in,
    input  logic [ADDR_W-1:0] wr_add,
    input  logic              acc_mode,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_add,
    output logic [ROW_W-1:0]  out,
    output logic              out_valid,
    output logic [SUM_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              clr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] C_LAST_ROW = ADDR_W'(DEPTH - 1);

    psum_row_t         r_mem [DEPTH];

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;
    logic              w_busy;

    logic              r_s1_valid;
    logic              r_s1_acc;
    logic [ADDR_W-1:0] r_s1_addr;
    psum_row_t         r_s1_data;
    psum_row_t         r_s1_old;
    psum_row_t         w_s1_result;

    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_accept;
    logic              w_rd_accept;
    psum_row_t         w_wr_old;
    psum_row_t         w_rd_row;

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full_range
            assign w_wr_in_range = 1'b1;
            assign w_rd_in_range = 1'b1;
        end else begin : g_part_range
            localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
            assign w_wr_in_range = ({1'b0, wr_add} < C_DEPTH);
            assign w_rd_in_range = ({1'b0, rd_add} < C_DEPTH);
        end
    endgenerate

    assign w_busy      = (r_state == ST_CLEAR);
    assign busy        = w_busy;
    assign in_ready    = ~w_busy;
    // clr in the same cycle drops the write so it cannot race the clear.
    assign w_wr_accept = in_valid & ~w_busy & ~clr & w_wr_in_range;
    assign w_rd_accept = rd_en & ~w_busy;

    // Clear FSM next state: one zero row per cycle, clr ignored once running.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                if (r_clr_cnt == C_LAST_ROW) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Clear FSM state register; reset always (re)starts a full clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Stage-1 result: overwrite or per-lane saturating accumulate.
    always_comb begin
        w_s1_result = r_s1_data;
        if (r_s1_acc) begin
            for (int i = 0; i < COL; i++) begin
                w_s1_result[i] = sat_add(r_s1_old[i], r_s1_data[i]);
            end
        end
    end

    // Rows still sitting in stage 1 are not yet in r_mem, so forward them.
    always_comb begin
        w_wr_old = r_mem[wr_add];
        if (r_s1_valid && (r_s1_addr == wr_add)) begin
            w_wr_old = w_s1_result;
        end
        w_rd_row = r_mem[rd_add];
        if (r_s1_valid && (r_s1_addr == rd_add)) begin
            w_rd_row = w_s1_result;
        end
        if (!w_rd_in_range) begin
            w_rd_row = '0;
        end
    end

    // Stage-1 valid; reset flushes any in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_wr_accept;
        end
    end

    // Stage-1 payload capture for an accepted write.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_s1_addr <= wr_add;
            r_s1_acc  <= acc_mode;
            r_s1_data <= in;
            r_s1_old  <= w_wr_old;
        end
    end

    // Row storage: stage-1 commit and clear writes never overlap in time.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_s1_valid) begin
                r_mem[r_s1_addr] <= w_s1_result;
            end
            if (w_busy) begin
                r_mem[r_clr_cnt] <= '0;
            end
        end
    end

    // Read data register with a single-cycle valid pulse per read.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= w_rd_accept;
            if (w_rd_accept) begin
                out <= w_rd_row;
            end
        end
    end

    psum_abs_sum u_abs_sum (
        .clk     (clk),
        .rst     (reset),
        .i_row   (out),
        .i_valid (out_valid),
        .o_sum   (sum_out),
        .o_valid (sum_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_psum_accum_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psum_accum_mem
//  Brief    : Directed self-checking bench for psum_accum_mem.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_psum_accum_mem;
    import core_pkg::*;

    localparam int ADDR_W = 4;
    typedef logic [ROW_W-1:0] row_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    row_t              in;
    logic [ADDR_W-1:0] wr_add;
    logic              acc_mode;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_add;
    row_t              out;
    logic              out_valid;
    logic [SUM_W-1:0]  sum_out;
    logic              sum_valid;
    logic              clr;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    psum_accum_mem #(.DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .wr_add    (wr_add),
        .acc_mode  (acc_mode),
        .rd_en     (rd_en),
        .rd_add    (rd_add),
        .out       (out),
        .out_valid (out_valid),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .clr       (clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               rd;
        bit               acc;
        int               addr;
        row_t             data;
        row_t             exp_row;
        logic [SUM_W-1:0] exp_sum;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input row_t act, input row_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic row_t mk8(input int a0, input int a1, input int a2, input int a3,
                                 input int a4, input int a5, input int a6, input int a7);
        int   v[8];
        row_t r;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7};
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[BW_PSUM*i +: BW_PSUM] = v[i][BW_PSUM-1:0];
        end
        return r;
    endfunction

    function automatic row_t rep(input int x);
        return mk8(x, x, x, x, x, x, x, x);
    endfunction

    function automatic vec_t mkv(input bit rd, input bit acc, input int addr,
                                 input row_t data, input row_t exp_row, input int exp_sum);
        vec_t v;
        v.rd      = rd;
        v.acc     = acc;
        v.addr    = addr;
        v.data    = data;
        v.exp_row = exp_row;
        v.exp_sum = exp_sum[SUM_W-1:0];
        return v;
    endfunction

    task automatic do_write(input int addr, input row_t data, input bit acc);
        in_valid = 1'b1;
        wr_add   = addr[ADDR_W-1:0];
        in       = data;
        acc_mode = acc;
        step();
        in_valid = 1'b0;
        acc_mode = 1'b0;
    endtask

    task automatic do_read(input int addr, input row_t exp_row, input logic [SUM_W-1:0] exp_sum,
                           input string tag);
        rd_en  = 1'b1;
        rd_add = addr[ADDR_W-1:0];
        step();
        rd_en = 1'b0;
        chk({tag, " out_valid"}, row_t'(out_valid), row_t'(1'b1));
        chk({tag, " out"}, out, exp_row);
        step();
        chk({tag, " sum_valid"}, row_t'(sum_valid), row_t'(1'b1));
        chk({tag, " out_valid pulse"}, row_t'(out_valid), '0);
        chk({tag, " sum_out"}, row_t'(sum_out), row_t'(exp_sum));
    endtask

    // Counts busy cycles (bounded), and out_valid pulses / in_ready highs seen during them.
    task automatic measure_busy(input string tag, input bit hold_rd, input int exp_n);
        int n      = 0;
        int pulses = 0;
        int rdy_hi = 0;
        while (busy && n < 100) begin
            if (out_valid) pulses++;
            if (in_ready !== 1'b0) rdy_hi++;
            n++;
            step();
        end
        if (out_valid) pulses++;
        rd_en    = 1'b0;
        in_valid = 1'b0;
        chk({tag, " busy cycles"}, row_t'(n), row_t'(exp_n));
        chk({tag, " in_ready while busy"}, row_t'(rdy_hi), '0);
        chk({tag, " in_ready after"}, row_t'(in_ready), row_t'(1'b1));
        if (hold_rd) chk({tag, " out_valid while busy"}, row_t'(pulses), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in = '0; wr_add = '0; acc_mode = 1'b0;
        rd_en = 1'b0; rd_add = '0; clr = 1'b0;
        step();
        step();
        reset = 1'b0;

        // 1: reset state and the clear that follows it
        chk("reset out", out, '0);
        chk("reset out_valid", row_t'(out_valid), '0);
        chk("reset sum_out", row_t'(sum_out), '0);
        chk("reset sum_valid", row_t'(sum_valid), '0);
        chk("reset busy", row_t'(busy), row_t'(1'b1));
        measure_busy("reset", 1'b0, 16);
        for (int r = 0; r < 16; r++) do_read(r, '0, '0, $sformatf("post-reset row %0d", r));

        // 2 + 4: table of overwrites, accumulates (incl. saturation) and reads
        vecs.push_back(mkv(0, 0, 3, mk8(1, -2, 3, -4, 5, -6, 7, -8), '0, 0));
        vecs.push_back(mkv(1, 0, 3, '0, mk8(1, -2, 3, -4, 5, -6, 7, -8), 36));
        vecs.push_back(mkv(0, 0, 7, rep(524287), '0, 0));
        vecs.push_back(mkv(1, 0, 7, '0, rep(524287), 4194296));
        vecs.push_back(mkv(0, 1, 7, mk8(1, -524288, -524288, -524288, -524288, -524288, -524288, -524288), '0, 0));
        vecs.push_back(mkv(1, 0, 7, '0, mk8(524287, -1, -1, -1, -1, -1, -1, -1), 524294));
        vecs.push_back(mkv(0, 1, 7, mk8(-1, -524288, -524288, -524288, -524288, -524288, -524288, -524288), '0, 0));
        vecs.push_back(mkv(1, 0, 7, '0, mk8(524286, -524288, -524288, -524288, -524288, -524288, -524288, -524288), 4194302));
        vecs.push_back(mkv(0, 1, 7, mk8(0, -524288, -524288, -524288, -524288, -524288, -524288, -524288), '0, 0));
        vecs.push_back(mkv(1, 0, 7, '0, mk8(524286, -524288, -524288, -524288, -524288, -524288, -524288, -524288), 4194302));
        vecs.push_back(mkv(0, 0, 0, rep(-3), '0, 0));
        vecs.push_back(mkv(1, 0, 0, '0, rep(-3), 24));
        vecs.push_back(mkv(0, 1, 0, mk8(5, 0, 0, 0, 0, 0, 0, -100), '0, 0));
        vecs.push_back(mkv(1, 0, 0, '0, mk8(2, -3, -3, -3, -3, -3, -3, -103), 123));
        vecs.push_back(mkv(1, 0, 9, '0, '0, 0));
        vecs.push_back(mkv(1, 0, 3, '0, mk8(1, -2, 3, -4, 5, -6, 7, -8), 36));
        foreach (vecs[i]) begin
            if (vecs[i].rd) do_read(vecs[i].addr, vecs[i].exp_row, vecs[i].exp_sum, $sformatf("vec %0d", i));
            else            do_write(vecs[i].addr, vecs[i].data, vecs[i].acc);
        end

        // 3: four back-to-back accumulates, read in the next cycle through forwarding
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; wr_add = 4'd5; in = rep(10); acc_mode = 1'b1;
            step();
        end
        in_valid = 1'b0; acc_mode = 1'b0;
        do_read(5, rep(40), 320, "b2b acc fwd");
        do_read(5, rep(40), 320, "b2b acc mem");

        // same-cycle read and write of one row: read sees the pre-write row
        in_valid = 1'b1; wr_add = 4'd3; in = rep(7); acc_mode = 1'b0;
        rd_en = 1'b1; rd_add = 4'd3;
        step();
        in_valid = 1'b0; rd_en = 1'b0;
        chk("same-cycle rd out_valid", row_t'(out_valid), row_t'(1'b1));
        chk("same-cycle rd out", out, mk8(1, -2, 3, -4, 5, -6, 7, -8));
        step();
        chk("same-cycle rd sum_out", row_t'(sum_out), row_t'(36));
        do_read(3, rep(7), 56, "after same-cycle wr");

        // 5: clr with a simultaneous write (dropped); a stage-1 write to row 0 still pending
        do_write(2, rep(9), 1'b0);
        do_read(2, rep(9), 72, "row2 before clr");
        do_write(0, rep(9), 1'b0);
        clr = 1'b1; in_valid = 1'b1; wr_add = 4'd2; in = rep(5); acc_mode = 1'b0;
        step();
        clr = 1'b0;
        rd_en = 1'b1; rd_add = 4'd2;
        measure_busy("clr", 1'b1, 16);
        do_read(2, '0, '0, "row2 after clr");
        do_read(0, '0, '0, "row0 after clr");
        do_read(3, '0, '0, "row3 after clr");

        // clr while busy is ignored: total clear length stays 16
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (3) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        measure_busy("clr during busy", 1'b0, 12);

        // 6: reset in the middle of a clear restarts a full clear
        for (int r = 10; r < 16; r++) do_write(r, rep(r + 100), 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid-clear reset out_valid", row_t'(out_valid), '0);
        measure_busy("mid-clear reset", 1'b0, 16);
        for (int r = 0; r < 16; r++) do_read(r, '0, '0, $sformatf("post-restart row %0d", r));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
